// File: rtl/seq_op_controller_pkg.sv
// Shared definitions for the SequencerCell sequencer: seq_op bit map,
// command/status encodings, compare type and controller state.
package seq_op_controller_pkg;

  localparam int OP_CFG_BIT  = 0;
  localparam int OP_SET_BIT  = 1;
  localparam int OP_SCAN_BIT = 2;
  localparam int OP_INX_BIT  = 3;

  typedef enum logic [1:0] {
    CMD_CFG       = 2'd0,
    CMD_SCAN_INDX = 2'd1,
    CMD_SCAN_PAGE = 2'd2,
    CMD_RSVD      = 2'd3
  } cmd_op_t;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_NOCFG   = 2'd1,
    ST_TIMEOUT = 2'd2,
    ST_BADOP   = 2'd3
  } rsp_status_t;

  // {equ, gtr} as driven on the head cell's rsltO
  typedef logic [1:0] compare_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CFGP,
    SETP,
    SCANP,
    SETTLE,
    RESP
  } state_t;

endpackage

// File: rtl/seq_timeout_timer.sv
// Loadable down-counter shared by the FETCH timeout and the SETTLE delay.
module seq_timeout_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/seq_op_controller.sv
// Single-master sequencer: fetches the DRAM row, pulses CFG/SET/SCAN to the
// cell array, waits for rsltO to settle and returns the head compare result.
module seq_op_controller
  import seq_op_controller_pkg::*;
#(
  parameter int CELL_SIZE = 8,
  parameter int OP_BITS   = 8,
  parameter int RSLT_LAT  = 2,
  parameter int FETCH_TMO = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [CELL_SIZE-1:0] cmd_target,
  output logic                 dram_req,
  input  logic                 dram_rdy,
  output logic [OP_BITS-1:0]   seq_op,
  output logic [CELL_SIZE-1:0] target,
  input  logic [1:0]           rslt_in,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [1:0]           rsp_cmp,
  output logic [1:0]           rsp_status,
  output logic [15:0]          clk_count,
  output logic                 busy
);

  localparam int TMR_W = ($clog2(FETCH_TMO + 1) > 4) ? $clog2(FETCH_TMO + 1) : 4;

  state_t             state;
  cmd_op_t            op_q;
  cmd_op_t            op_in;
  logic               configured;
  logic               accept;
  logic               op_good;
  logic               tmr_load;
  logic [TMR_W-1:0]   tmr_val;
  logic               tmr_en;
  logic               tmr_zero;

  assign op_in = cmd_op_t'(cmd_op);

  // The timer is loaded once per phase: on a good accept for the fetch window,
  // and while leaving SCANP for the settle delay.
  always_comb begin
    accept   = cmd_valid && cmd_ready;
    op_good  = accept && (op_in != CMD_RSVD) && (configured || (op_in == CMD_CFG));
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_en   = 1'b0;
    if (op_good) begin
      tmr_load = 1'b1;
      tmr_val  = TMR_W'(FETCH_TMO - 1);
    end else if (state == SCANP) begin
      tmr_load = 1'b1;
      tmr_val  = TMR_W'(RSLT_LAT - 1);
    end
    if ((state == FETCH) && !dram_rdy) tmr_en = 1'b1;
    if (state == SETTLE) tmr_en = 1'b1;
  end

  seq_timeout_timer #(
    .W(TMR_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_count <= '0;
    end else begin
      clk_count <= clk_count + 16'd1;
    end
  end

  // Outputs are registered alongside the state so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      op_q       <= CMD_CFG;
      configured <= 1'b0;
      target     <= '0;
      seq_op     <= '0;
      dram_req   <= 1'b0;
      cmd_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_cmp    <= '0;
      rsp_status <= ST_OK;
      busy       <= 1'b0;
    end else begin
      seq_op <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_q      <= op_in;
            target    <= cmd_target;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (op_in == CMD_RSVD) begin
              state      <= RESP;
              rsp_valid  <= 1'b1;
              rsp_status <= ST_BADOP;
              rsp_cmp    <= '0;
            end else if (!op_good) begin
              state      <= RESP;
              rsp_valid  <= 1'b1;
              rsp_status <= ST_NOCFG;
              rsp_cmp    <= '0;
            end else begin
              state    <= FETCH;
              dram_req <= 1'b1;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        FETCH: begin
          if (dram_rdy) begin
            if (op_q == CMD_CFG) begin
              state              <= CFGP;
              seq_op[OP_CFG_BIT] <= 1'b1;
            end else begin
              state              <= SETP;
              seq_op[OP_SET_BIT] <= 1'b1;
              seq_op[OP_INX_BIT] <= (op_q == CMD_SCAN_INDX);
            end
          end else if (tmr_zero) begin
            state      <= RESP;
            dram_req   <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_status <= ST_TIMEOUT;
            rsp_cmp    <= '0;
          end
        end
        CFGP: begin
          configured <= 1'b1;
          state      <= RESP;
          dram_req   <= 1'b0;
          rsp_valid  <= 1'b1;
          rsp_status <= ST_OK;
          rsp_cmp    <= '0;
        end
        SETP: begin
          state               <= SCANP;
          seq_op[OP_SCAN_BIT] <= 1'b1;
          seq_op[OP_INX_BIT]  <= (op_q == CMD_SCAN_INDX);
        end
        SCANP: begin
          state    <= SETTLE;
          dram_req <= 1'b0;
        end
        SETTLE: begin
          if (tmr_zero) begin
            state      <= RESP;
            rsp_valid  <= 1'b1;
            rsp_status <= ST_OK;
            rsp_cmp    <= rslt_in;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
